mem_stall_ctrl: RTL and testbench

Arbitrates the single byte-wide RAM port between instruction fetch (IF) and the data-memory stage (MEM). It serialises word, half and byte transfers into byte beats. It also generates the 6-bit pipeline stall vector consumed by PC, IF_ID, ID_EX, EX_MEM, MEM_WB and WB, so the pipeline freezes or bubbles while memory is busy. It sits between the pipeline stage registers and the RAM.

---
 rtl/mem_stall_ctrl_pkg.sv | 39 +++
 rtl/mem_stall_ctrl_stall_gen.sv | 31 +++
 rtl/mem_stall_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_mem_stall_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stall_ctrl_pkg.sv
// rtl/mem_stall_ctrl_pkg.sv - shared constants, state encoding and size helper for mem_stall_ctrl
//
// Purpose: Stop/NoStop levels, transfer size codes, stall vector encodings,
//          FSM state encoding and the size-code to byte-count helper.
// Ports:   none (package).
package mem_stall_ctrl_pkg;

    localparam logic STOP   = 1'b1;
    localparam logic NOSTOP = 1'b0;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // bit0 PC, bit1 IF_ID, bit2 ID_EX, bit3 EX_MEM, bit4 MEM_WB, bit5 WB
    localparam logic [5:0] STALL_MEM  = {NOSTOP, {5{STOP}}};
    localparam logic [5:0] STALL_ID   = {{3{NOSTOP}}, {3{STOP}}};
    localparam logic [5:0] STALL_IF   = {{4{NOSTOP}}, {2{STOP}}};
    localparam logic [5:0] STALL_NONE = {6{NOSTOP}};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_IF_RD  = 3'd1,
        ST_MEM_RD = 3'd2,
        ST_MEM_WR = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    // Byte beats needed for a size code; codes 2 and 3 both mean a word.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_BYTE: return 3'd1;
            SIZE_HALF: return 3'd2;
            SIZE_WORD: return 3'd4;
            default:   return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_stall_ctrl_stall_gen.sv
// rtl/mem_stall_ctrl_stall_gen.sv - combinational pipeline stall priority encoder
//
// Purpose: picks the 6-bit stall vector from the outstanding memory/hazard
//          requests, MEM first, then the ID load-use hazard, then IF.
// Ports:   mem_req_i/mem_done_i     MEM request and its completion pulse
//          id_stall_req_i           load-use hazard request from ID
//          if_req_i/if_done_i       IF request and its completion pulse
//          stall_o                  stall vector, 1 = Stop
module mem_stall_ctrl_stall_gen
    import mem_stall_ctrl_pkg::*;
(
    input  logic       mem_req_i,
    input  logic       mem_done_i,
    input  logic       id_stall_req_i,
    input  logic       if_req_i,
    input  logic       if_done_i,
    output logic [5:0] stall_o
);

    always_comb begin
        stall_o = STALL_NONE;
        if (mem_req_i && !mem_done_i) begin
            stall_o = STALL_MEM;
        end else if (id_stall_req_i) begin
            stall_o = STALL_ID;
        end else if (if_req_i && !if_done_i) begin
            stall_o = STALL_IF;
        end
    end

endmodule

// File: rtl/mem_stall_ctrl.sv
// rtl/mem_stall_ctrl.sv - byte-wide RAM port arbiter for IF/MEM with pipeline stall generation
//
// Purpose: grants the single byte-wide RAM port to MEM (priority) or IF,
//          serialises byte/half/word transfers into byte beats and drives
//          the pipeline stall vector.
// Ports:   clk, rst                       clock, synchronous active-high reset
//          if_req/if_addr/if_flush        IF word read request, address, abort
//          if_done/if_data                IF completion pulse and fetched word
//          mem_req/mem_we/mem_size/...    MEM transfer request
//          mem_done/mem_rdata             MEM completion pulse and read data
//          id_stall_req                   load-use hazard request
//          ram_a/ram_dout/ram_wr/ram_din  byte RAM port (read data one cycle late)
//          stall                          stall vector, 1 = Stop
module mem_stall_ctrl
    import mem_stall_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_done,
    output logic [DATA_W-1:0] if_data,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_size,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_done,
    output logic [DATA_W-1:0] mem_rdata,
    input  logic              id_stall_req,
    output logic [ADDR_W-1:0] ram_a,
    output logic [7:0]        ram_dout,
    output logic              ram_wr,
    input  logic [7:0]        ram_din,
    output logic [5:0]        stall
);

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        n_q, n_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              if_done_q, if_done_d;
    logic              mem_done_q, mem_done_d;
    logic [DATA_W-1:0] if_data_q, if_data_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;

    // ram_din carries the byte addressed on the previous beat, so the lane
    // being filled lags cnt by one.
    logic [1:0] rd_lane;
    logic       rd_active;
    logic       wr_active;
    logic [5:0] stall_raw;

    assign rd_lane   = cnt_q[1:0] - 2'd1;
    assign rd_active = ((state_q == ST_IF_RD) || (state_q == ST_MEM_RD)) && (cnt_q < n_q);
    assign wr_active = (state_q == ST_MEM_WR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd0;
            n_q         <= 3'd0;
            base_q      <= '0;
            wdata_q     <= '0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            if_data_q   <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        n_d         = n_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (mem_req) begin
                    base_d  = mem_addr;
                    n_d     = size_bytes(mem_size);
                    wdata_d = mem_wdata;
                    cnt_d   = 3'd0;
                    if (mem_we) begin
                        state_d = ST_MEM_WR;
                    end else begin
                        // Cleared up front so unread upper bytes come out as zero.
                        mem_rdata_d = '0;
                        state_d     = ST_MEM_RD;
                    end
                end else if (if_req) begin
                    base_d    = if_addr;
                    n_d       = 3'd4;
                    cnt_d     = 3'd0;
                    if_data_d = '0;
                    state_d   = ST_IF_RD;
                end
            end
            ST_IF_RD: begin
                if (if_flush) begin
                    state_d = ST_IDLE;
                    cnt_d   = 3'd0;
                end else begin
                    if (cnt_q != 3'd0) begin
                        if_data_d[{rd_lane, 3'b000} +: 8] = ram_din;
                    end
                    if (cnt_q == n_q) begin
                        state_d   = ST_DONE;
                        if_done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            ST_MEM_RD: begin
                if (cnt_q != 3'd0) begin
                    mem_rdata_d[{rd_lane, 3'b000} +: 8] = ram_din;
                end
                if (cnt_q == n_q) begin
                    state_d    = ST_DONE;
                    mem_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_MEM_WR: begin
                if (cnt_q == n_q - 3'd1) begin
                    state_d    = ST_DONE;
                    mem_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_DONE: begin
                // No grant here: gives the requester a cycle to drop req.
                state_d = ST_IDLE;
                cnt_d   = 3'd0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // RAM side is gated by rst so a write in flight stops in the reset cycle.
    assign ram_wr   = wr_active && !rst;
    assign ram_a    = ((rd_active || wr_active) && !rst) ? (base_q + ADDR_W'(cnt_q)) : '0;
    assign ram_dout = ram_wr ? wdata_q[{cnt_q[1:0], 3'b000} +: 8] : 8'h00;

    // A flush arriving while the IF result sits in DONE kills the pulse.
    assign if_done   = if_done_q && !if_flush && !rst;
    assign mem_done  = mem_done_q && !rst;
    assign if_data   = if_data_q;
    assign mem_rdata = mem_rdata_q;

    mem_stall_ctrl_stall_gen u_stall_gen (
        .mem_req_i      (mem_req),
        .mem_done_i     (mem_done),
        .id_stall_req_i (id_stall_req),
        .if_req_i       (if_req),
        .if_done_i      (if_done),
        .stall_o        (stall_raw)
    );

    assign stall = rst ? STALL_NONE : stall_raw;

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// tb/tb_mem_stall_ctrl.sv - self-checking bench for mem_stall_ctrl
module tb_mem_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_flush, if_done;
    logic [31:0] if_addr, if_data;
    logic        mem_req, mem_we, mem_done;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        id_stall_req;
    logic [31:0] ram_a;
    logic [7:0]  ram_dout, ram_din;
    logic        ram_wr;
    logic [5:0]  stall;

    always #5 clk = ~clk;

    mem_stall_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_done(if_done), .if_data(if_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_done(mem_done), .mem_rdata(mem_rdata),
        .id_stall_req(id_stall_req),
        .ram_a(ram_a), .ram_dout(ram_dout), .ram_wr(ram_wr), .ram_din(ram_din),
        .stall(stall)
    );

    // 256-byte RAM aliased on the low address byte; shadow is the model's copy.
    logic [7:0]  ram    [256];
    logic [7:0]  shadow [256];
    logic [31:0] wr_a_q [$];
    logic [7:0]  wr_d_q [$];

    always @(posedge clk) begin
        if (ram_wr) begin
            ram[ram_a[7:0]] <= ram_dout;
            wr_a_q.push_back(ram_a);
            wr_d_q.push_back(ram_dout);
        end
        ram_din <= ram[ram_a[7:0]];
    end

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr, input int n);
        logic [31:0] v;
        v = '0;
        for (int b = 0; b < n; b++) v[8*b +: 8] = shadow[8'(addr + 32'(b))];
        return v;
    endfunction

    function automatic int mem_diff();
        int d;
        d = 0;
        for (int i = 0; i < 256; i++) if (ram[i] !== shadow[i]) d++;
        return d;
    endfunction

    task automatic set_byte(input int idx, input logic [7:0] v);
        ram[idx]    <= v;
        shadow[idx] = v;
    endtask

    // kind: 0 = IF read, 1 = MEM read, 2 = MEM write
    task automatic do_txn(input int kind, input logic [31:0] addr, input logic [1:0] size,
                          input logic [31:0] wdata);
        int n, exp_lat, k;
        logic done, got, addr_ok, stall_ok;
        logic [31:0] exp_data;
        logic [5:0]  busy;
        n        = (kind == 0) ? 4 : nbytes(size);
        exp_lat  = (kind == 2) ? n + 1 : n + 2;
        exp_data = model_read(addr, n);
        busy     = (kind == 0) ? 6'b000011 : 6'b011111;
        @(posedge clk); #1;
        if (kind == 0) begin
            if_req = 1'b1; if_addr = addr;
        end else begin
            mem_req = 1'b1; mem_we = (kind == 2); mem_size = size;
            mem_addr = addr; mem_wdata = wdata;
        end
        k = 0; got = 1'b0; addr_ok = 1'b1; stall_ok = 1'b1;
        while (!got && k < 20) begin
            @(posedge clk); #1;
            k++;
            done = (kind == 0) ? if_done : mem_done;
            if (done) begin
                got = 1'b1;
            end else begin
                if (stall !== busy) stall_ok = 1'b0;
                if (k <= n && ram_a !== addr + 32'(k - 1)) addr_ok = 1'b0;
                if (kind == 2 && k <= n && (ram_wr !== 1'b1 || ram_dout !== wdata[8*(k-1) +: 8]))
                    addr_ok = 1'b0;
            end
        end
        check_eq("latency", k, exp_lat);
        check_eq("beat_addr", addr_ok, 1'b1);
        check_eq("busy_stall", stall_ok, 1'b1);
        check_eq("done_stall", stall, 6'b000000);
        if (kind == 0) check_eq("if_data", if_data, exp_data);
        if (kind == 1) check_eq("mem_rdata", mem_rdata, exp_data);
        if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
        if (kind == 2) for (int b = 0; b < n; b++) shadow[8'(addr + 32'(b))] = wdata[8*b +: 8];
        @(posedge clk); #1;
        check_eq("done_pulse", (kind == 0) ? if_done : mem_done, 1'b0);
        if (kind == 2) check_eq("ram_image", mem_diff(), 0);
    endtask

    initial begin
        int k, mem_k, if_k;
        logic st_ok, early, seen;
        logic [31:0] v, exp_if;
        rst = 1'b1; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
        mem_req = 1'b0; mem_we = 1'b0; mem_size = 2'd0; mem_addr = '0; mem_wdata = '0;
        id_stall_req = 1'b0;
        for (int i = 0; i < 256; i++) set_byte(i, 8'($urandom));

        // reset state; stall held low while rst is high
        repeat (2) @(posedge clk);
        #1 mem_req = 1'b1; if_req = 1'b1;
        #1 check_eq("rst_stall", stall, 6'b000000);
        check_eq("rst_ram_wr", ram_wr, 1'b0);
        mem_req = 1'b0; if_req = 1'b0;
        @(posedge clk); #1;
        check_eq("rst_if_done", if_done, 1'b0);
        check_eq("rst_mem_done", mem_done, 1'b0);
        check_eq("rst_ram_a", ram_a, 32'h0);
        check_eq("rst_idle_stall", stall, 6'b000000);
        rst = 1'b0;

        // 1: IF word fetch
        set_byte(0, 8'h13); set_byte(1, 8'h05); set_byte(2, 8'h00); set_byte(3, 8'h00);
        do_txn(0, 32'h100, 2'd2, 32'h0);
        check_eq("t1_word", if_data, 32'h00000513);

        // 2: simultaneous requests, MEM first then IF
        set_byte(0, 8'hEF); set_byte(1, 8'hBE); set_byte(2, 8'hAD); set_byte(3, 8'hDE);
        exp_if = model_read(32'h10, 4);
        @(posedge clk); #1;
        mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd2; mem_addr = 32'h200;
        if_req = 1'b1; if_addr = 32'h10;
        k = 0; mem_k = 0; if_k = 0; st_ok = 1'b1; early = 1'b0;
        while (if_k == 0 && k < 40) begin
            @(posedge clk); #1;
            k++;
            if (mem_k == 0) begin
                if (if_done) early = 1'b1;
                if (mem_done) begin
                    mem_k = k;
                    check_eq("t2_mrdata", mem_rdata, 32'hDEADBEEF);
                    check_eq("t2_stall_after", stall, 6'b000011);
                    mem_req = 1'b0;
                end else if (stall !== 6'b011111) st_ok = 1'b0;
            end else if (if_done) begin
                if_k = k;
                check_eq("t2_if_data", if_data, exp_if);
            end
        end
        if_req = 1'b0;
        check_eq("t2_mem_lat", mem_k, 6);
        check_eq("t2_stall_mem", st_ok, 1'b1);
        check_eq("t2_if_early", early, 1'b0);
        check_eq("t2_if_lat", if_k, 13);

        // 3: half write wrapping past the top of the address space
        wr_a_q.delete(); wr_d_q.delete();
        do_txn(2, 32'hFFFFFFFF, 2'd1, 32'h00001234);
        check_eq("t3_nwr", wr_a_q.size(), 2);
        if (wr_a_q.size() == 2) begin
            check_eq("t3_a0", wr_a_q[0], 32'hFFFFFFFF);
            check_eq("t3_d0", wr_d_q[0], 8'h34);
            check_eq("t3_a1", wr_a_q[1], 32'h00000000);
            check_eq("t3_d1", wr_d_q[1], 8'h12);
        end

        // 4: flush at cnt=2 of an IF read
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h20;
        repeat (3) @(posedge clk);
        #1 check_eq("t4_cnt2_addr", ram_a, 32'h22);
        if_flush = 1'b1;
        @(posedge clk); #1;
        check_eq("t4_abort_addr", ram_a, 32'h0);
        check_eq("t4_abort_done", if_done, 1'b0);
        if_req = 1'b0; if_flush = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (if_done) seen = 1'b1;
        end
        check_eq("t4_no_done", seen, 1'b0);
        do_txn(0, 32'h20, 2'd2, 32'h0);

        // 5: reset during a word write at cnt=1
        v = $urandom;
        @(posedge clk); #1;
        mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd2; mem_addr = 32'h40; mem_wdata = v;
        repeat (2) @(posedge clk);
        #1 check_eq("t5_addr_pre", ram_a, 32'h41);
        rst = 1'b1;
        #1 check_eq("t5_wr_rst", ram_wr, 1'b0);
        check_eq("t5_stall_rst", stall, 6'b000000);
        @(posedge clk); #1;
        check_eq("t5_if_data", if_data, 32'h0);
        check_eq("t5_mem_rdata", mem_rdata, 32'h0);
        check_eq("t5_mem_done", mem_done, 1'b0);
        check_eq("t5_ram_a", ram_a, 32'h0);
        mem_req = 1'b0; mem_we = 1'b0; rst = 1'b0;
        shadow[8'h40] = v[7:0];
        @(posedge clk); #1;
        check_eq("t5_ram_image", mem_diff(), 0);

        // 6: ID hazard stall and its priority below MEM
        id_stall_req = 1'b1;
        #1 check_eq("t6_id", stall, 6'b000111);
        mem_req = 1'b1;
        #1 check_eq("t6_id_mem", stall, 6'b011111);
        mem_req = 1'b0; if_req = 1'b1;
        #1 check_eq("t6_id_if", stall, 6'b000111);
        if_req = 1'b0; id_stall_req = 1'b0;
        #1 check_eq("t6_none", stall, 6'b000000);

        // randomized transactions against the byte-array model
        for (int t = 0; t < 40; t++) begin
            do_txn($urandom_range(0, 2), $urandom, 2'($urandom_range(0, 3)), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
